// File: rtl/vga_sync_gen.sv
// vga_sync_gen
// Raster timing generator for a VGA display. It divides the system clock
// down to the pixel rate, walks the horizontal and vertical counters, and
// drives the active-low sync pulses and the blanked colour to the DAC pins.
// Colour and sync are both registered on the pixel tick, so they reach the
// pins aligned: one pixel after the coordinates that produced them.
//
// Ports:
//   clk         system clock
//   reset       synchronous, active-high reset
//   rgb_next    colour for the current (pixel_x, pixel_y); bit0=R bit1=G bit2=B
//   pixel_x     horizontal count, 0..H_TOTAL-1
//   pixel_y     vertical count, 0..V_TOTAL-1
//   video_on    high inside the active area (decoded from the counters)
//   pixel_tick  one-clk enable, once per pixel period
//   frame_tick  one-clk pulse as the raster enters vertical blanking
//   hsync       active-low horizontal sync, registered
//   vsync       active-low vertical sync, registered
//   rgb         registered, blanked colour
//
// H_TOTAL and V_TOTAL must not exceed 1024 (10-bit counters).
module vga_sync_gen #(
  parameter int CLK_DIV   = 2,
  parameter int H_DISPLAY = 640,
  parameter int H_FRONT   = 16,
  parameter int H_SYNC    = 96,
  parameter int H_BACK    = 48,
  parameter int V_DISPLAY = 480,
  parameter int V_FRONT   = 10,
  parameter int V_SYNC    = 2,
  parameter int V_BACK    = 33
) (
  input  logic       clk,
  input  logic       reset,
  input  logic [2:0] rgb_next,
  output logic [9:0] pixel_x,
  output logic [9:0] pixel_y,
  output logic       video_on,
  output logic       pixel_tick,
  output logic       frame_tick,
  output logic       hsync,
  output logic       vsync,
  output logic [2:0] rgb
);

  localparam int H_TOTAL = H_DISPLAY + H_FRONT + H_SYNC + H_BACK;
  localparam int V_TOTAL = V_DISPLAY + V_FRONT + V_SYNC + V_BACK;

  // A divide-by-one still needs a one-bit divider register.
  localparam int DIV_W = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
  localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(CLK_DIV - 1);

  localparam logic [9:0] H_LAST     = 10'(H_TOTAL - 1);
  localparam logic [9:0] V_LAST     = 10'(V_TOTAL - 1);
  localparam logic [9:0] H_ACT      = 10'(H_DISPLAY);
  localparam logic [9:0] V_ACT      = 10'(V_DISPLAY);
  localparam logic [9:0] V_ACT_LAST = 10'(V_DISPLAY - 1);
  localparam logic [9:0] HS_FIRST   = 10'(H_DISPLAY + H_FRONT);
  localparam logic [9:0] HS_LAST    = 10'(H_DISPLAY + H_FRONT + H_SYNC - 1);
  localparam logic [9:0] VS_FIRST   = 10'(V_DISPLAY + V_FRONT);
  localparam logic [9:0] VS_LAST    = 10'(V_DISPLAY + V_FRONT + V_SYNC - 1);

  logic [DIV_W-1:0] divider;
  logic             x_last;
  logic             y_last;
  logic             hs_raw;
  logic             vs_raw;

  always_ff @(posedge clk) begin
    if (reset) begin
      divider <= '0;
    end else if (divider == DIV_LAST) begin
      divider <= '0;
    end else begin
      divider <= divider + DIV_W'(1);
    end
  end

  assign pixel_tick = (divider == DIV_LAST);

  assign x_last = (pixel_x == H_LAST);
  assign y_last = (pixel_y == V_LAST);

  always_ff @(posedge clk) begin
    if (reset) begin
      pixel_x <= '0;
      pixel_y <= '0;
    end else if (pixel_tick) begin
      if (x_last) begin
        pixel_x <= '0;
        pixel_y <= y_last ? 10'd0 : pixel_y + 10'd1;
      end else begin
        pixel_x <= pixel_x + 10'd1;
      end
    end
  end

  assign video_on = (pixel_x < H_ACT) && (pixel_y < V_ACT);
  assign hs_raw   = !((pixel_x >= HS_FIRST) && (pixel_x <= HS_LAST));
  assign vs_raw   = !((pixel_y >= VS_FIRST) && (pixel_y <= VS_LAST));

  // Fires on the tick that moves the raster from the last active line into
  // the first blank line; the wrap at the end of the frame does not count.
  assign frame_tick = pixel_tick && x_last && (pixel_y == V_ACT_LAST);

  // Colour and sync share one register stage so they stay aligned at the pins.
  always_ff @(posedge clk) begin
    if (reset) begin
      rgb   <= 3'b000;
      hsync <= 1'b1;
      vsync <= 1'b1;
    end else if (pixel_tick) begin
      rgb   <= video_on ? rgb_next : 3'b000;
      hsync <= hs_raw;
      vsync <= vs_raw;
    end
  end

endmodule
